// File: rtl/versat_addr_gen.sv
// Nested-loop RAM address generator (IDLE/DELAY/RUN) for one Versat memory port.
// Optional pause input is enabled by defining VERSAT_ADDR_GEN_PAUSE_EN.
module versat_addr_gen #(
  parameter int unsigned ADDR_W   = 6,
  parameter int unsigned PERIOD_W = 10,
  parameter int unsigned ITER_W   = 10
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                run,
  input  logic [ADDR_W-1:0]   start,
  input  logic [ADDR_W-1:0]   incr,
  input  logic [ADDR_W-1:0]   shift,
  input  logic [PERIOD_W-1:0] period,
  input  logic [PERIOD_W-1:0] duty,
  input  logic [PERIOD_W-1:0] delay,
  input  logic [ITER_W-1:0]   iterations,
  input  logic                wr,
`ifdef VERSAT_ADDR_GEN_PAUSE_EN
  input  logic                pause,
`endif
  output logic [ADDR_W-1:0]   addr,
  output logic                mem_en,
  output logic                mem_we,
  output logic                done
);

  typedef enum logic [1:0] {S_IDLE, S_DELAY, S_RUN} state_e;

  localparam logic [PERIOD_W-1:0] PER_ONE  = PERIOD_W'(1);
  localparam logic [ITER_W-1:0]   ITER_ONE = ITER_W'(1);

  state_e                state_q, state_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [PERIOD_W-1:0]   dly_cnt_q, dly_cnt_d;
  logic [PERIOD_W-1:0]   per_cnt_q, per_cnt_d;
  logic [ITER_W-1:0]     iter_cnt_q, iter_cnt_d;
  logic                  zero_q, zero_d;

  logic [ADDR_W-1:0]     start_q, start_d;
  logic [ADDR_W-1:0]     incr_q, incr_d;
  logic [ADDR_W-1:0]     shift_q, shift_d;
  logic [PERIOD_W-1:0]   period_q, period_d;
  logic [PERIOD_W-1:0]   duty_q, duty_d;
  logic [ITER_W-1:0]     iter_q, iter_d;
  logic                  wr_q, wr_d;

  logic hold;
  logic last_per;

`ifdef VERSAT_ADDR_GEN_PAUSE_EN
  assign hold = pause;
`else
  assign hold = 1'b0;
`endif

  assign last_per = (per_cnt_q == (period_q - PER_ONE));

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    dly_cnt_d  = dly_cnt_q;
    per_cnt_d  = per_cnt_q;
    iter_cnt_d = iter_cnt_q;
    zero_d     = 1'b0;
    start_d    = start_q;
    incr_d     = incr_q;
    shift_d    = shift_q;
    period_d   = period_q;
    duty_d     = duty_q;
    iter_d     = iter_q;
    wr_d       = wr_q;

    case (state_q)
      S_IDLE: begin
        if (run) begin
          start_d  = start;
          incr_d   = incr;
          shift_d  = shift;
          period_d = period;
          duty_d   = duty;
          iter_d   = iterations;
          wr_d     = wr;
          if ((iterations == '0) || (period == '0)) begin
            zero_d = 1'b1;
          end else if (delay != '0) begin
            state_d   = S_DELAY;
            dly_cnt_d = delay - PER_ONE;
          end else begin
            // Shadows load on this same edge, so take the start address from the port.
            state_d    = S_RUN;
            addr_d     = start;
            per_cnt_d  = '0;
            iter_cnt_d = '0;
          end
        end
      end

      S_DELAY: begin
        if (!hold) begin
          if (dly_cnt_q == '0) begin
            state_d    = S_RUN;
            addr_d     = start_q;
            per_cnt_d  = '0;
            iter_cnt_d = '0;
          end else begin
            dly_cnt_d = dly_cnt_q - PER_ONE;
          end
        end
      end

      S_RUN: begin
        if (!hold) begin
          if (!last_per) begin
            addr_d    = addr_q + incr_q;
            per_cnt_d = per_cnt_q + PER_ONE;
          end else begin
            addr_d     = addr_q + shift_q;
            per_cnt_d  = '0;
            iter_cnt_d = iter_cnt_q + ITER_ONE;
            if (iter_cnt_q == (iter_q - ITER_ONE)) begin
              state_d = S_IDLE;
            end
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      dly_cnt_q  <= '0;
      per_cnt_q  <= '0;
      iter_cnt_q <= '0;
      zero_q     <= 1'b0;
      start_q    <= '0;
      incr_q     <= '0;
      shift_q    <= '0;
      period_q   <= '0;
      duty_q     <= '0;
      iter_q     <= '0;
      wr_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      dly_cnt_q  <= dly_cnt_d;
      per_cnt_q  <= per_cnt_d;
      iter_cnt_q <= iter_cnt_d;
      zero_q     <= zero_d;
      start_q    <= start_d;
      incr_q     <= incr_d;
      shift_q    <= shift_d;
      period_q   <= period_d;
      duty_q     <= duty_d;
      iter_q     <= iter_d;
      wr_q       <= wr_d;
    end
  end

  assign addr   = addr_q;
  assign mem_en = (state_q == S_RUN) && (per_cnt_q < duty_q) && !hold;
  assign mem_we = mem_en && wr_q;
  assign done   = (state_q == S_IDLE) && !zero_q;

endmodule

// File: tb/tb_versat_addr_gen.sv
// Randomized self-checking bench for versat_addr_gen against a closed-form address model.
module tb_versat_addr_gen;

  localparam int unsigned ADDR_W   = 6;
  localparam int unsigned PERIOD_W = 10;
  localparam int unsigned ITER_W   = 10;

  logic                clk;
  logic                rst_n;
  logic                run;
  logic [ADDR_W-1:0]   start;
  logic [ADDR_W-1:0]   incr;
  logic [ADDR_W-1:0]   shift;
  logic [PERIOD_W-1:0] period;
  logic [PERIOD_W-1:0] duty;
  logic [PERIOD_W-1:0] delay;
  logic [ITER_W-1:0]   iterations;
  logic                wr;
  logic [ADDR_W-1:0]   addr;
  logic                mem_en;
  logic                mem_we;
  logic                done;
`ifdef VERSAT_ADDR_GEN_PAUSE_EN
  logic                pause;
  initial pause = 1'b0;
`endif

  int n_total = 0;
  int n_bad   = 0;

  versat_addr_gen #(
    .ADDR_W   (ADDR_W),
    .PERIOD_W (PERIOD_W),
    .ITER_W   (ITER_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (run),
    .start      (start),
    .incr       (incr),
    .shift      (shift),
    .period     (period),
    .duty       (duty),
    .delay      (delay),
    .iterations (iterations),
    .wr         (wr),
`ifdef VERSAT_ADDR_GEN_PAUSE_EN
    .pause      (pause),
`endif
    .addr       (addr),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic scramble();
    start      = ADDR_W'($urandom);
    incr       = ADDR_W'($urandom);
    shift      = ADDR_W'($urandom);
    period     = PERIOD_W'($urandom_range(0, 9));
    duty       = PERIOD_W'($urandom_range(0, 9));
    delay      = PERIOD_W'($urandom_range(0, 9));
    iterations = ITER_W'($urandom_range(0, 9));
    wr         = 1'($urandom);
  endtask

  // Called at a negedge while the DUT is idle; returns at the negedge of the first idle cycle after.
  task automatic run_seq(input int st, input int inc, input int sh, input int per, input int dt,
                         input int dly, input int it, input int w, input bit poke);
    int ea;
    int n;
    start      = ADDR_W'(st);
    incr       = ADDR_W'(inc);
    shift      = ADDR_W'(sh);
    period     = PERIOD_W'(per);
    duty       = PERIOD_W'(dt);
    delay      = PERIOD_W'(dly);
    iterations = ITER_W'(it);
    wr         = 1'(w);
    run        = 1'b1;
    @(posedge clk);
    @(negedge clk);
    run = 1'b0;
    scramble();
    for (int c = 0; c < dly; c++) begin
      chk($sformatf("delay%0d.done", c), 32'(done), 0);
      chk($sformatf("delay%0d.en", c), 32'(mem_en), 0);
      @(negedge clk);
    end
    n = 0;
    for (int i = 0; i < it; i++) begin
      for (int p = 0; p < per; p++) begin
        ea = (st + i * ((per - 1) * inc + sh) + p * inc) & ((1 << ADDR_W) - 1);
        chk($sformatf("run%0d.addr", n), 32'(addr), 32'(ea));
        chk($sformatf("run%0d.en", n), 32'(mem_en), 32'(p < dt));
        chk($sformatf("run%0d.we", n), 32'(mem_we), 32'((p < dt) && (w != 0)));
        chk($sformatf("run%0d.done", n), 32'(done), 0);
        run = poke ? 1'($urandom_range(0, 2) == 0) : 1'b0;
        n++;
        @(negedge clk);
      end
    end
    run = 1'b0;
    chk("end.done", 32'(done), 1);
    chk("end.en", 32'(mem_en), 0);
  endtask

  task automatic zero_len(input int per, input int it);
    period     = PERIOD_W'(per);
    iterations = ITER_W'(it);
    delay      = '0;
    duty       = PERIOD_W'(5);
    run        = 1'b1;
    @(posedge clk);
    @(negedge clk);
    run = 1'b0;
    chk("zero.drop", 32'(done), 0);
    chk("zero.en0", 32'(mem_en), 0);
    @(negedge clk);
    chk("zero.back", 32'(done), 1);
    chk("zero.en1", 32'(mem_en), 0);
  endtask

  initial begin
    rst_n = 1'b0;
    run   = 1'b0;
    scramble();
    repeat (2) @(negedge clk);
    chk("rst.addr", 32'(addr), 0);
    chk("rst.en", 32'(mem_en), 0);
    chk("rst.we", 32'(mem_we), 0);
    chk("rst.done", 32'(done), 1);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle.done", 32'(done), 1);

    // Directed cases: linear read, 2D stride with delay, negative wrap.
    run_seq(4, 1, 1, 4, 4, 0, 2, 0, 1'b0);
    run_seq(0, 1, 5, 3, 2, 3, 2, 1, 1'b0);
    run_seq(1, 63, 63, 3, 3, 0, 1, 0, 1'b0);

    zero_len(4, 0);
    zero_len(0, 3);

    // Mid-RUN asynchronous reset, then a clean restart.
    start = 6'd9; incr = 6'd2; shift = 6'd3; period = 10'd5; duty = 10'd5;
    delay = '0; iterations = 10'd3; wr = 1'b1; run = 1'b1;
    @(posedge clk);
    @(negedge clk);
    run = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid.en_before", 32'(mem_en), 1);
    rst_n = 1'b0;
    #1;
    chk("mid.addr", 32'(addr), 0);
    chk("mid.en", 32'(mem_en), 0);
    chk("mid.we", 32'(mem_we), 0);
    chk("mid.done", 32'(done), 1);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("mid.idle", 32'(done), 1);
    run_seq(4, 1, 1, 4, 4, 0, 2, 0, 1'b0);

    // Randomized back-to-back sequences with stray run pulses during RUN.
    for (int k = 0; k < 40; k++) begin
      run_seq(int'($urandom_range(0, 63)), int'($urandom_range(0, 63)),
              int'($urandom_range(0, 63)), int'($urandom_range(1, 6)),
              int'($urandom_range(0, 7)), int'($urandom_range(0, 4)),
              int'($urandom_range(1, 4)), int'($urandom_range(0, 1)), 1'b1);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/versat_addr_gen.md
# versat_addr_gen

Nested-loop address generator that drives one port of a Versat memory unit's dual-port RAM (addr/en/we of port A or B). After a `run` pulse it waits a programmable delay, then for `iterations` outer loops emits `period` addresses each. The address moves by a signed `incr` every cycle and by a signed `shift` at each period boundary, with enable asserted for the first `duty` cycles of each period. It reports completion on `done`; the RAM's registered read data follows one cycle after each enabled address.

## Interface
- `ADDR_W`, 6: RAM address width; also the width of `start`, `incr`, `shift`.
- `PERIOD_W`, 10: width of `period`, `duty`, `delay`.
- `ITER_W`, 10: width of `iterations`.

- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `run`  in  1  start pulse; sampled only in IDLE.
- `start`  in  ADDR_W  initial address.
- `incr`  in  ADDR_W  signed two's-complement per-cycle step.
- `shift`  in  ADDR_W  signed two's-complement per-period step, replaces `incr` on the last cycle of a period.
- `period`  in  PERIOD_W  cycles per outer iteration.
- `duty`  in  PERIOD_W  enabled cycles at the start of each period.
- `delay`  in  PERIOD_W  wait cycles before the first address.
- `iterations`  in  ITER_W  outer-loop count.
- `wr`  in  1  direction; 1 = write sequence.
- `addr`  out  ADDR_W  RAM address.
- `mem_en`  out  1  RAM port enable.
- `mem_we`  out  1  RAM port write enable.
- `done`  out  1  idle/complete level.

## Operation
- States are IDLE, DELAY and RUN.
- Configuration inputs are latched into shadow registers on the edge where `run`=1 in IDLE. Input changes after that edge have no effect until the next run.
- IDLE with `run`=1:
  - `iterations`=0 or `period`=0: stay in IDLE. `done` drops for exactly one cycle, then returns to 1. No `mem_en`.
  - else `delay`>0: go to DELAY, load `dly_cnt`=`delay`-1.
  - else: go to RUN.
- DELAY: decrement `dly_cnt`; when it is 0, go to RUN.
- Entering RUN: `addr_r`=`start`, `per_cnt`=0, `iter_cnt`=0.
- Each RUN cycle:
  - If `per_cnt`≠`period`-1: `addr_r` += `incr`, `per_cnt`++.
  - Else: `addr_r` += `shift`, `per_cnt`=0, `iter_cnt`++.
  - If `iter_cnt`=`iterations`-1 and `per_cnt`=`period`-1, go to IDLE.
- Address arithmetic is modulo 2^ADDR_W. `incr` and `shift` are sign-extended implicitly by wrap-around; no saturation.
- Outputs:
  - `addr` = `addr_r`.
  - `mem_en` = (state==RUN) && (`per_cnt` < `duty`).
  - `duty` ≥ `period` means enabled for the whole period; `duty`=0 means never enabled, but the counters still run.
  - `mem_we` = `mem_en` && `wr_r`.
- `done` = (state==IDLE), except during the one-cycle drop in the zero-length case.
- `run` outside IDLE is ignored; there is no restart mid-sequence.
- Reset at any time returns immediately to IDLE. Reset values: `addr`=0, `mem_en`=0, `mem_we`=0, `done`=1, all counters 0, shadow registers 0.

## Timing
- Let `run` be sampled at edge T0.
  - With `delay`=d>0: DELAY occupies cycles T0..T0+d-1, and the first address is valid in the cycle after edge T0+d.
  - With `delay`=0: the first address is valid in the cycle after T0.
- RUN lasts exactly `iterations`×`period` cycles. `done` rises on the edge that ends the last RUN cycle.
- The next `run` is accepted in the first IDLE cycle, i.e. back-to-back with zero gap.
- `addr`, `mem_en` and `mem_we` are decoded only from registers, with no combinational path from inputs. The RAM samples them at the next edge; read data is valid one cycle after that.

## Configuration
- `VERSAT_ADDR_GEN_PAUSE_EN`
  - Defined: adds input port `pause` (1 bit). While `pause`=1 in DELAY or RUN, all counters and `addr_r` hold and `mem_en`/`mem_we` are forced to 0. Resume continues from the held values. `pause` has no effect in IDLE.
  - Undefined: there is no `pause` port and counters advance every cycle.

## Test plan
- Reset mid-RUN: `rst_n` low for 1 cycle while RUN -> outputs `addr`=0, `mem_en`=0, `done`=1 asynchronously. A subsequent `run` starts cleanly.
- Linear read: `start`=4, `incr`=1, `shift`=1, `period`=4, `duty`=4, `iterations`=2, `delay`=0, `wr`=0 -> `addr` 4,5,6,7,8,9,10,11 with `mem_en`=1 and `mem_we`=0 for 8 cycles, then `done`=1.
- 2D stride with duty and delay: `start`=0, `incr`=1, `shift`=5, `period`=3, `duty`=2, `iterations`=2, `delay`=3, `wr`=1 -> 3 idle cycles, then `addr` 0,1,2,7,8,9 with `mem_en` pattern 1,1,0,1,1,0 and `mem_we` equal to `mem_en`.
- Negative step and wrap: `start`=1, `incr`=63 (−1), `shift`=63, `period`=3, `duty`=3, `iterations`=1, ADDR_W=6 -> `addr` 1,0,63.
- Zero-length and ignored run: `iterations`=0 -> `done` low for exactly 1 cycle and no `mem_en`. Also, `run` re-pulsed during RUN -> sequence unchanged.
- With `VERSAT_ADDR_GEN_PAUSE_EN`: linear case above with `pause`=1 for 2 cycles after the third address -> `addr` holds at 7 with `mem_en`=0 for 2 cycles, then resumes 7,8,9,10,11. Total is 10 cycles.
